// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AXI-to-APB bridge: requester indices, default widths
// and the command record carried from the arbiter into the APB command FIFO.
package apb_bridge_pkg;

   localparam int DEF_ADDR_W    = 32;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_TAG_DEPTH = 4;

   localparam logic REQ_WR = 1'b0;
   localparam logic REQ_RD = 1'b1;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
      logic                  write;
   } cmd_t;

endpackage

// File: rtl/apb_tag_fifo.sv
// Small FIFO recording which requester owns each command in flight on APB,
// so completions can be routed back in issue order.
module apb_tag_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic             pclk,
   input  logic             preset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)      count <= count + 1'b1;
         else if (pop_ok && !push_ok) count <= count - 1'b1;
      end
   end

   // NOTE: entries are not reset; count alone decides which slots hold live tags.
   always_ff @(posedge pclk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter between the AXI write and read paths feeding one APB master;
// tracks command ownership and returns one completion strobe per command, in order.
module apb_req_arbiter
   import apb_bridge_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   input  logic [1:0]        req_write,
   output logic              fifo_push,
   input  logic              fifo_full,
   output logic [ADDR_W-1:0] fifo_addr,
   output logic [DATA_W-1:0] fifo_wdata,
   output logic              fifo_write,
   input  logic              cmd_done,
   input  logic [DATA_W-1:0] PRDATA,
   output logic [1:0]        rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              err_sticky
);

   logic rr_last;
   logic gnt;
   logic gnt_idx;
   logic tag_full;
   logic tag_empty;
   logic tag_head;
   logic tag_pop;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      gnt     = 1'b0;
      gnt_idx = REQ_WR;
      if (req_valid == 2'b11) gnt_idx = ~rr_last;
      else                    gnt_idx = req_valid[REQ_RD];
      // Reset also forces the combinational handshake low.
      if (!preset && !fifo_full && !tag_full && (req_valid != 2'b00)) gnt = 1'b1;
   end

   assign req_ready[REQ_WR] = gnt && (gnt_idx == REQ_WR);
   assign req_ready[REQ_RD] = gnt && (gnt_idx == REQ_RD);
   assign fifo_push         = gnt;
   assign fifo_addr         = gnt_idx ? req_addr1  : req_addr0;
   assign fifo_wdata        = gnt_idx ? req_wdata1 : req_wdata0;
   assign fifo_write        = req_write[gnt_idx];

   assign tag_pop = cmd_done && !tag_empty;

   apb_tag_fifo #(
      .WIDTH (1),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .pclk      (pclk),
      .preset    (preset),
      .push      (gnt),
      .pop       (tag_pop),
      .push_data (gnt_idx),
      .head      (tag_head),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) rr_last <= 1'b1;
      else if (gnt) rr_last <= gnt_idx;
   end

   // Completion with nothing outstanding is a protocol error, held until reset.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         rsp_valid  <= 2'b00;
         rsp_rdata  <= '0;
         err_sticky <= 1'b0;
      end else begin
         rsp_valid <= 2'b00;
         if (tag_pop) begin
            rsp_valid[tag_head] <= 1'b1;
            rsp_rdata           <= PRDATA;
         end
         if (cmd_done && tag_empty) err_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// a randomized run against a queue-based reference model.
module tb_apb_req_arbiter;
   import apb_bridge_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TD = 4;

   logic          pclk = 1'b0;
   logic          preset;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [AW-1:0] req_addr0, req_addr1;
   logic [DW-1:0] req_wdata0, req_wdata1;
   logic [1:0]    req_write;
   logic          fifo_push;
   logic          fifo_full;
   logic [AW-1:0] fifo_addr;
   logic [DW-1:0] fifo_wdata;
   logic          fifo_write;
   logic          cmd_done;
   logic [DW-1:0] PRDATA;
   logic [1:0]    rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          err_sticky;

   always #5 pclk = ~pclk;

   apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
      .pclk       (pclk),
      .preset     (preset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr0  (req_addr0),
      .req_addr1  (req_addr1),
      .req_wdata0 (req_wdata0),
      .req_wdata1 (req_wdata1),
      .req_write  (req_write),
      .fifo_push  (fifo_push),
      .fifo_full  (fifo_full),
      .fifo_addr  (fifo_addr),
      .fifo_wdata (fifo_wdata),
      .fifo_write (fifo_write),
      .cmd_done   (cmd_done),
      .PRDATA     (PRDATA),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .err_sticky (err_sticky)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change after the falling edge; combinational outputs are sampled 1 ns later.
   task automatic set_in(input logic [1:0] v, input logic ff, input logic done, input logic [31:0] prd);
      @(negedge pclk);
      req_valid = v;
      fifo_full = ff;
      cmd_done  = done;
      PRDATA    = prd;
      #1;
   endtask

   task automatic to_edge();
      @(posedge pclk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge pclk);
      preset    = 1'b1;
      req_valid = 2'b11;
      fifo_full = 1'b0;
      cmd_done  = 1'b0;
      PRDATA    = '0;
      #1;
      check("rst_ready", req_ready, 2'b00);
      check("rst_push", fifo_push, 1'b0);
      to_edge();
      check("rst_rsp_valid", rsp_valid, 2'b00);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_err", err_sticky, 1'b0);
      @(negedge pclk);
      preset    = 1'b0;
      req_valid = 2'b00;
   endtask

   task automatic fixed_payload();
      req_addr0  = 32'h0000_1000;
      req_addr1  = 32'h0000_2000;
      req_wdata0 = 32'hD0D0_0000;
      req_wdata1 = 32'hD1D1_1111;
      req_write  = 2'b01;
   endtask

   typedef struct {
      logic [1:0]  v;
      logic        ff;
      logic        done;
      logic [31:0] prd;
      logic [1:0]  ready;
      logic [1:0]  rsp;
      logic        chk_rd;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      int   tag;
      logic wr;
   } ent_t;

   vec_t vt[10];

   initial begin
      cmd_t        pay[2];
      ent_t        q[$];
      ent_t        e;
      int          m_rr;
      logic        m_err;
      logic [1:0]  prev_ready;
      logic [1:0]  v, exp_ready, exp_rsp;
      logic        ff, done, chk_rd;
      logic [31:0] prd;
      int          g;

      vt[0] = '{2'b11, 1'b0, 1'b0, 32'h0,         2'b01, 2'b00, 1'b0, 32'h0};
      vt[1] = '{2'b11, 1'b0, 1'b1, 32'h1111_1111, 2'b10, 2'b01, 1'b0, 32'h0};
      vt[2] = '{2'b11, 1'b0, 1'b1, 32'hA5A5_0001, 2'b01, 2'b10, 1'b1, 32'hA5A5_0001};
      vt[3] = '{2'b11, 1'b0, 1'b0, 32'h0,         2'b10, 2'b00, 1'b0, 32'h0};
      vt[4] = '{2'b11, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 32'h0};
      vt[5] = '{2'b11, 1'b0, 1'b0, 32'h0,         2'b01, 2'b00, 1'b0, 32'h0};
      vt[6] = '{2'b00, 1'b0, 1'b1, 32'h0,         2'b00, 2'b01, 1'b0, 32'h0};
      vt[7] = '{2'b00, 1'b0, 1'b1, 32'h7777_0007, 2'b00, 2'b10, 1'b1, 32'h7777_0007};
      vt[8] = '{2'b00, 1'b0, 1'b1, 32'h0,         2'b00, 2'b01, 1'b0, 32'h0};
      vt[9] = '{2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 32'h0};

      preset = 1'b1;
      fixed_payload();
      do_reset();

      // Directed table: contention, FIFO backpressure and in-order completions.
      for (int i = 0; i < 10; i++) begin
         set_in(vt[i].v, vt[i].ff, vt[i].done, vt[i].prd);
         check($sformatf("vec%0d_ready", i), req_ready, vt[i].ready);
         check($sformatf("vec%0d_push", i), fifo_push, |vt[i].ready);
         if (vt[i].ready != 2'b00)
            check($sformatf("vec%0d_addr", i), fifo_addr, vt[i].ready[1] ? 32'h2000 : 32'h1000);
         to_edge();
         check($sformatf("vec%0d_rsp", i), rsp_valid, vt[i].rsp);
         if (vt[i].chk_rd) check($sformatf("vec%0d_rdata", i), rsp_rdata, vt[i].rdata);
      end
      check("table_err", err_sticky, 1'b0);

      // Single write request, completion three cycles later.
      do_reset();
      set_in(2'b01, 1'b0, 1'b0, 32'h0);
      check("single_ready", req_ready, 2'b01);
      check("single_push", fifo_push, 1'b1);
      check("single_addr", fifo_addr, 32'h1000);
      check("single_write", fifo_write, 1'b1);
      to_edge();
      check("single_rsp_early", rsp_valid, 2'b00);
      set_in(2'b00, 1'b0, 1'b0, 32'h0); to_edge();
      set_in(2'b00, 1'b0, 1'b0, 32'h0); to_edge();
      set_in(2'b00, 1'b0, 1'b1, 32'h0); to_edge();
      check("single_rsp", rsp_valid, 2'b01);
      set_in(2'b00, 1'b0, 1'b0, 32'h0); to_edge();
      check("single_rsp_once", rsp_valid, 2'b00);

      // Tag queue full: blocked even with a same-cycle completion.
      do_reset();
      for (int i = 0; i < TD; i++) begin
         set_in(2'b01, 1'b0, 1'b0, 32'h0);
         check($sformatf("fill%0d_ready", i), req_ready, 2'b01);
         to_edge();
      end
      set_in(2'b01, 1'b0, 1'b0, 32'h0);
      check("full_ready", req_ready, 2'b00);
      check("full_push", fifo_push, 1'b0);
      to_edge();
      set_in(2'b01, 1'b0, 1'b1, 32'h0);
      check("full_done_ready", req_ready, 2'b00);
      to_edge();
      check("full_done_rsp", rsp_valid, 2'b01);
      set_in(2'b01, 1'b0, 1'b0, 32'h0);
      check("after_full_ready", req_ready, 2'b01);
      to_edge();

      // Completion with nothing outstanding.
      do_reset();
      set_in(2'b00, 1'b0, 1'b1, 32'h0);
      to_edge();
      check("empty_done_err", err_sticky, 1'b1);
      check("empty_done_rsp", rsp_valid, 2'b00);
      set_in(2'b00, 1'b0, 1'b0, 32'h0); to_edge();
      set_in(2'b00, 1'b0, 1'b0, 32'h0); to_edge();
      check("err_holds", err_sticky, 1'b1);

      // Reset with three tags outstanding.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(2'b01, 1'b0, 1'b0, 32'h0);
         check($sformatf("pre_rst%0d_ready", i), req_ready, 2'b01);
         to_edge();
      end
      @(negedge pclk);
      preset    = 1'b1;
      req_valid = 2'b11;
      #1;
      check("mid_rst_ready", req_ready, 2'b00);
      check("mid_rst_push", fifo_push, 1'b0);
      check("mid_rst_rsp", rsp_valid, 2'b00);
      to_edge();
      @(negedge pclk);
      preset    = 1'b0;
      req_valid = 2'b00;
      set_in(2'b00, 1'b0, 1'b0, 32'h0); to_edge();
      check("post_rst_no_rsp", rsp_valid, 2'b00);
      set_in(2'b00, 1'b0, 1'b1, 32'h0); to_edge();
      check("post_rst_count0_err", err_sticky, 1'b1);
      check("post_rst_count0_rsp", rsp_valid, 2'b00);
      set_in(2'b11, 1'b0, 1'b0, 32'h0);
      check("post_rst_contention", req_ready, 2'b01);
      to_edge();

      // Randomized run against the queue model.
      do_reset();
      q.delete();
      m_rr       = 1;
      m_err      = 1'b0;
      prev_ready = 2'b00;
      req_valid  = 2'b00;
      for (int i = 0; i < 2; i++) pay[i] = '{addr: $urandom, wdata: $urandom, write: 1'(i == 0)};
      for (int n = 0; n < 800; n++) begin
         // A requester only changes its payload when idle or just accepted.
         for (int i = 0; i < 2; i++)
            if (!req_valid[i] || prev_ready[i]) begin
               pay[i].addr  = $urandom;
               pay[i].wdata = $urandom;
               pay[i].write = 1'($urandom_range(0, 1));
            end
         req_addr0  = pay[0].addr;
         req_addr1  = pay[1].addr;
         req_wdata0 = pay[0].wdata;
         req_wdata1 = pay[1].wdata;
         req_write  = {pay[1].write, pay[0].write};
         v    = 2'($urandom_range(0, 3));
         ff   = ($urandom_range(0, 3) == 0);
         done = ($urandom_range(0, 9) < 4);
         prd  = $urandom;
         set_in(v, ff, done, prd);

         g = -1;
         if (!ff && q.size() < TD && v != 2'b00) begin
            if (v == 2'b11)      g = 1 - m_rr;
            else if (v == 2'b01) g = 0;
            else                 g = 1;
         end
         exp_ready = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
         check($sformatf("rnd%0d_ready", n), req_ready, exp_ready);
         check($sformatf("rnd%0d_push", n), fifo_push, g >= 0);
         if (g >= 0) begin
            check($sformatf("rnd%0d_addr", n), fifo_addr, pay[g].addr);
            check($sformatf("rnd%0d_wdata", n), fifo_wdata, pay[g].wdata);
            check($sformatf("rnd%0d_write", n), fifo_write, pay[g].write);
         end
         to_edge();

         exp_rsp = 2'b00;
         chk_rd  = 1'b0;
         if (done) begin
            if (q.size() > 0) begin
               e       = q.pop_front();
               exp_rsp = (e.tag == 0) ? 2'b01 : 2'b10;
               chk_rd  = !e.wr;
            end else begin
               m_err = 1'b1;
            end
         end
         if (g >= 0) begin
            q.push_back('{tag: g, wr: pay[g].write});
            m_rr = g;
         end
         prev_ready = exp_ready;
         check($sformatf("rnd%0d_rsp", n), rsp_valid, exp_rsp);
         if (chk_rd) check($sformatf("rnd%0d_rdata", n), rsp_rdata, prd);
         check($sformatf("rnd%0d_err", n), err_sticky, m_err);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
